// File: rtl/cal_eep_spi_responder_if.sv
// cal_eep_spi_responder_if: SPI pin bundle between the command processor and the calibration EEPROM model
//   SS_n : slave select, active low (master -> slave)
//   SCLK : SPI clock, mode 0, idle low (master -> slave)
//   MOSI : master out, MSB first (master -> slave)
//   MISO : slave out, MSB first (slave -> master)
interface cal_eep_spi_responder_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    modport master (output SS_n, SCLK, MOSI, input MISO);
    modport slave (input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/cal_eep_spi_responder.sv
// cal_eep_spi_responder: SPI slave model of the calibration EEPROM (16-bit op/addr/data frames)
//   clk         : system clock, oversamples the SPI pins
//   rst_n       : asynchronous active-low reset
//   spi         : SPI pins (slave modport)
//   o_wr_done   : one-clk pulse when a write frame commits
//   o_rd_done   : one-clk pulse when a read frame completes cleanly
//   o_frm_err   : one-clk pulse when a frame ends with a bit count other than 16
//   o_busy      : high while a frame is in progress
module cal_eep_spi_responder #(
    parameter int         ADDR_W  = 6,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cal_eep_spi_responder_if.slave  spi,
    output logic                    o_wr_done,
    output logic                    o_rd_done,
    output logic                    o_frm_err,
    output logic                    o_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [1:0] {IDLE, SHIFT_HDR, SHIFT_DATA, FINISH} state_t;
    state_t r_state, w_next;
    logic [2:0] r_ss, r_sclk;
    logic [1:0] r_mosi;
    logic [4:0] r_cnt;
    logic [7:0] r_hdr, r_dat, r_out_sr;
    logic       r_first;
    logic [7:0] r_mem [DEPTH];
    logic       w_ss_fall, w_ss_rise, w_rise, w_fall, w_act, w_fin_ok;
    logic [7:0] w_hdr_nx;
    logic [1:0] w_op;
    logic [ADDR_W-1:0] w_addr;
    // Stage [1] is the synchronized level; stage [2] is one clk older for edge detection.
    // SS_n resets to 0 so a master already holding SS_n low at release must go high then low.
    assign w_ss_fall = r_ss[2] & ~r_ss[1];
    assign w_ss_rise = ~r_ss[2] & r_ss[1];
    assign w_rise    = r_sclk[1] & ~r_sclk[2];
    assign w_fall    = ~r_sclk[1] & r_sclk[2];
    // SCLK edges are dropped in the cycle SS_n rises so they never alter the count.
    assign w_act     = (r_state == SHIFT_HDR || r_state == SHIFT_DATA) && !w_ss_rise;
    assign w_hdr_nx  = {r_hdr[6:0], r_mosi[1]};
    assign w_op      = r_hdr[7:6];
    assign w_addr    = r_hdr[ADDR_W-1:0];
    assign w_fin_ok  = r_state == FINISH && r_cnt == 5'd16;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:       w_next = w_ss_fall ? SHIFT_HDR : IDLE;
            SHIFT_HDR:  w_next = w_ss_rise ? FINISH : (w_rise && r_cnt == 5'd7) ? SHIFT_DATA : SHIFT_HDR;
            SHIFT_DATA: w_next = w_ss_rise ? FINISH : SHIFT_DATA;
            default:    w_next = IDLE;
        endcase
    end
    always_comb begin
        o_wr_done = w_fin_ok && w_op == 2'b01;
        o_rd_done = w_fin_ok && w_op == 2'b00;
        o_frm_err = r_state == FINISH && r_cnt != 5'd16;
        o_busy    = r_state != IDLE;
        spi.MISO  = r_state == SHIFT_DATA && r_out_sr[7];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss     <= '0;
            r_sclk   <= '0;
            r_mosi   <= '0;
            r_cnt    <= '0;
            r_hdr    <= '0;
            r_dat    <= '0;
            r_out_sr <= '0;
            r_first  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
        end else begin
            r_ss   <= {r_ss[1:0], spi.SS_n};
            r_sclk <= {r_sclk[1:0], spi.SCLK};
            r_mosi <= {r_mosi[0], spi.MOSI};
            if (r_state == IDLE && w_ss_fall) r_cnt <= '0;
            if (w_act && w_rise) r_cnt <= (r_cnt == 5'd31) ? r_cnt : r_cnt + 5'd1;
            if (r_state == SHIFT_HDR && w_act && w_rise) begin
                r_hdr <= w_hdr_nx;
                if (r_cnt == 5'd7) begin
                    r_out_sr <= (w_hdr_nx[7:6] == 2'b00) ? r_mem[w_hdr_nx[ADDR_W-1:0]] : 8'h00;
                    r_first  <= 1'b1;
                end
            end
            if (r_state == SHIFT_DATA && w_act && w_rise && r_cnt < 5'd16) r_dat <= {r_dat[6:0], r_mosi[1]};
            // Bit 7 is already on MISO when the first data-phase fall arrives, so that fall only clears the flag.
            if (r_state == SHIFT_DATA && w_act && w_fall && r_cnt < 5'd16) begin
                r_first <= 1'b0;
                if (!r_first) r_out_sr <= {r_out_sr[6:0], 1'b0};
            end
            if (r_state == FINISH && r_cnt == 5'd16 && w_op == 2'b01) r_mem[w_addr] <= r_dat;
        end
    end
endmodule

// File: tb/tb_cal_eep_spi_responder.sv
// tb_cal_eep_spi_responder: directed SPI-master bench with a frame scoreboard for the calibration EEPROM model
module tb_cal_eep_spi_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_done, rd_done, frm_err, busy;
    cal_eep_spi_responder_if spi();
    cal_eep_spi_responder #(.ADDR_W(6), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi.slave),
        .o_wr_done (wr_done),
        .o_rd_done (rd_done),
        .o_frm_err (frm_err),
        .o_busy    (busy)
    );
    always #5 clk = ~clk;
    typedef struct {
        string      tag;
        logic [7:0] rx;
        logic       wr, rd, err;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] model [64];
    int vectors = 0, miscompares = 0;
    int t_wr = 0, t_rd = 0, t_err = 0;
    always @(negedge clk) begin
        t_wr  += int'(wr_done);
        t_rd  += int'(rd_done);
        t_err += int'(frm_err);
    end
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic frame(input logic [15:0] f, input int nbits, input string tag);
        exp_t e;
        logic [7:0] rx;
        logic hdr_miso;
        logic [1:0] op;
        logic [5:0] a;
        int b_wr, b_rd, b_err;
        op = f[15:14];
        a = f[13:8];
        e.tag = tag;
        e.wr = nbits == 16 && op == 2'b01;
        e.rd = nbits == 16 && op == 2'b00;
        e.err = nbits != 16;
        e.rx = 8'h00;
        for (int i = 8; i < 16; i++)
            if (i < nbits && op == 2'b00) e.rx[15-i] = model[a][15-i];
        if (e.wr) model[a] = f[7:0];
        sb.push_back(e);
        b_wr = t_wr; b_rd = t_rd; b_err = t_err;
        rx = 8'h00;
        hdr_miso = 1'b0;
        spi.SS_n = 1'b0;
        wclk(4);
        for (int i = 0; i < nbits; i++) begin
            spi.MOSI = (i < 16) ? f[15-i] : 1'b0;
            wclk(5);
            spi.SCLK = 1'b1;
            if (i < 8) hdr_miso |= spi.MISO;
            else if (i < 16) rx[15-i] = spi.MISO;
            wclk(5);
            spi.SCLK = 1'b0;
        end
        wclk(4);
        chk({tag, ".busy_in_frame"}, {7'd0, busy}, 8'd1);
        spi.SS_n = 1'b1;
        wclk(4);
        e = sb.pop_front();
        chk({e.tag, ".rx"}, rx, e.rx);
        chk({e.tag, ".miso_hdr"}, {7'd0, hdr_miso}, 8'd0);
        chk({e.tag, ".wr_done"}, 8'(t_wr - b_wr), {7'd0, e.wr});
        chk({e.tag, ".rd_done"}, 8'(t_rd - b_rd), {7'd0, e.rd});
        chk({e.tag, ".frm_err"}, 8'(t_err - b_err), {7'd0, e.err});
        chk({e.tag, ".busy_after"}, {7'd0, busy}, 8'd0);
    endtask
    initial begin
        logic [15:0] frm;
        int b_sum;
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        wclk(3);
        chk("reset.outputs", {3'd0, busy, spi.MISO, wr_done, rd_done, frm_err}, 8'h00);
        rst_n = 1'b1;
        wclk(4);
        frame(16'h1300, 16, "rd13_init");
        frame(16'h535A, 16, "wr13_5A");
        frame(16'h1300, 16, "rd13_5A");
        frame(16'h1400, 16, "rd14");
        frame(16'h7FFF, 16, "wr3F_FF");
        frame(16'h4001, 16, "wr00_01");
        frame(16'h3F00, 16, "rd3F");
        frame(16'h0000, 16, "rd00");
        frame(16'h53A5, 12, "wr13_abort");
        frame(16'h1300, 16, "rd13_after_abort");
        frame(16'hD3C3, 16, "ignored_op");
        frame(16'h1300, 16, "rd13_after_ignored");
        frame(16'h5311, 17, "wr13_17clk");
        frame(16'h1300, 16, "rd13_after_17clk");
        frm = 16'h1300;
        b_sum = t_wr + t_rd + t_err;
        spi.SS_n = 1'b0;
        wclk(4);
        for (int i = 0; i < 10; i++) begin
            spi.MOSI = frm[15-i];
            wclk(5);
            spi.SCLK = 1'b1;
            wclk(5);
            spi.SCLK = 1'b0;
        end
        chk("midrst.busy_before", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.outputs", {3'd0, busy, spi.MISO, wr_done, rd_done, frm_err}, 8'h00);
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        wclk(3);
        rst_n = 1'b1;
        wclk(6);
        chk("midrst.ss_low_no_start", {7'd0, busy}, 8'd0);
        spi.SS_n = 1'b1;
        wclk(6);
        chk("midrst.no_pulses", 8'(t_wr + t_rd + t_err - b_sum), 8'd0);
        frame(16'h1300, 16, "rd13_after_rst");
        frame(16'h4A77, 16, "b2b_wr0A");
        frame(16'h0A00, 16, "b2b_rd0A");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
